// File: rtl/pad_io_pkg.sv
// Shared types and limits for the pad I/O bank.
package pad_io_pkg;

    localparam int unsigned PAD_IO_MAX_PINS = 32;

    typedef enum logic {
        PAD_PUSH_PULL  = 1'b0,
        PAD_OPEN_DRAIN = 1'b1
    } pad_mode_e;

    function automatic pad_mode_e pin_mode(input logic od);
        return od ? PAD_OPEN_DRAIN : PAD_PUSH_PULL;
    endfunction

endpackage

// File: rtl/pad_in_filter.sv
// One pin's input path: synchroniser, optional glitch filter, edge detect.
// Filter present only when PAD_IO_GLITCH_FILTER_EN is defined.
module pad_in_filter
    import pad_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT_W  = 4,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pad_in,
    input  logic [FILT_CNT_W-1:0] filt_thresh,
    output logic                  core_in,
    output logic                  rise,
    output logic                  fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f_q;
    logic                   f_d_q;

    // Sync chain starts at the pin's idle value so idle-high pins raise no spurious event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PAD_IO_GLITCH_FILTER_EN
    logic [FILT_CNT_W-1:0] cnt_q;

    // cnt never exceeds filt_thresh, so an all-ones threshold cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            f_q   <= RESET_VAL;
        end else if (s == f_q) begin
            cnt_q <= '0;
        end else if (cnt_q < filt_thresh) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            f_q   <= s;
            cnt_q <= '0;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^filt_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= RESET_VAL;
        end else begin
            f_q <= s;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_d_q <= RESET_VAL;
        end else begin
            f_d_q <= f_q;
        end
    end

    assign core_in = f_q;
    assign rise    = f_q & ~f_d_q;
    assign fall    = ~f_q & f_d_q;

endmodule

// File: rtl/pad_io_bank.sv
// N-pin pad bank: registered push-pull/open-drain drive, filtered inputs, sticky edge flags, irq.
// Optional input glitch filter enabled by defining PAD_IO_GLITCH_FILTER_EN.
module pad_io_bank
    import pad_io_pkg::*;
#(
    parameter int unsigned          NUM_PINS     = 24,
    parameter int unsigned          SYNC_STAGES  = 2,
    parameter int unsigned          FILT_CNT_W   = 4,
    parameter logic [NUM_PINS-1:0]  RESET_IN_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PINS-1:0]   core_out,
    input  logic [NUM_PINS-1:0]   core_oe,
    input  logic [NUM_PINS-1:0]   od_en,
    input  logic [NUM_PINS-1:0]   pad_in,
    output logic [NUM_PINS-1:0]   pad_out,
    output logic [NUM_PINS-1:0]   pad_oe,
    output logic [NUM_PINS-1:0]   core_in,
    output logic [NUM_PINS-1:0]   pad_snoop,
    input  logic [FILT_CNT_W-1:0] filt_thresh,
    input  logic [NUM_PINS-1:0]   rise_ie,
    input  logic [NUM_PINS-1:0]   fall_ie,
    input  logic [NUM_PINS-1:0]   evt_clr,
    output logic [NUM_PINS-1:0]   rise_sts,
    output logic [NUM_PINS-1:0]   fall_sts,
    output logic                  irq
);

    logic [NUM_PINS-1:0] out_d;
    logic [NUM_PINS-1:0] oe_d;
    logic [NUM_PINS-1:0] rise_evt;
    logic [NUM_PINS-1:0] fall_evt;

    // Open-drain never drives high: pad_out is forced low and only oe follows core_out.
    always_comb begin
        out_d = '0;
        oe_d  = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            unique case (pin_mode(od_en[i]))
                PAD_OPEN_DRAIN: begin
                    out_d[i] = 1'b0;
                    oe_d[i]  = ~core_out[i];
                end
                default: begin
                    out_d[i] = core_out[i];
                    oe_d[i]  = core_oe[i];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_out <= '0;
            pad_oe  <= '0;
        end else begin
            pad_out <= out_d;
            pad_oe  <= oe_d;
        end
    end

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
        pad_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CNT_W  (FILT_CNT_W),
            .RESET_VAL   (RESET_IN_VAL[g])
        ) u_filt (
            .clk         (clk),
            .rst         (rst),
            .pad_in      (pad_in[g]),
            .filt_thresh (filt_thresh),
            .core_in     (core_in[g]),
            .rise        (rise_evt[g]),
            .fall        (fall_evt[g])
        );
    end

    // A new event outranks a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_sts <= '0;
            fall_sts <= '0;
            irq      <= 1'b0;
        end else begin
            rise_sts <= (rise_sts & ~evt_clr) | rise_evt;
            fall_sts <= (fall_sts & ~evt_clr) | fall_evt;
            irq      <= |((rise_sts & rise_ie) | (fall_sts & fall_ie));
        end
    end

    assign pad_snoop = (pad_oe & pad_out) | (~pad_oe & core_in);

endmodule

// File: tb/tb_pad_io_bank.sv
// Directed self-checking bench for pad_io_bank (pin 8 idles high via RESET_IN_VAL).
module tb_pad_io_bank;

    localparam int unsigned NP = 24;
    localparam logic [NP-1:0] IDLE = 24'h000100;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] core_out, core_oe, od_en, pad_in;
    logic [NP-1:0] pad_out, pad_oe, core_in, pad_snoop;
    logic [3:0]    filt_thresh;
    logic [NP-1:0] rise_ie, fall_ie, evt_clr;
    logic [NP-1:0] rise_sts, fall_sts;
    logic          irq;

    int errors = 0;
    int checks = 0;

    pad_io_bank #(
        .NUM_PINS     (NP),
        .SYNC_STAGES  (2),
        .FILT_CNT_W   (4),
        .RESET_IN_VAL (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_out    (core_out),
        .core_oe     (core_oe),
        .od_en       (od_en),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .core_in     (core_in),
        .pad_snoop   (pad_snoop),
        .filt_thresh (filt_thresh),
        .rise_ie     (rise_ie),
        .fall_ie     (fall_ie),
        .evt_clr     (evt_clr),
        .rise_sts    (rise_sts),
        .fall_sts    (fall_sts),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] od;
        logic [NP-1:0] oe;
        logic [NP-1:0] out;
        logic [NP-1:0] exp_out;
        logic [NP-1:0] exp_oe;
    } vec_t;

    vec_t vecs[8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        evt_clr = '1;
        step(1);
        evt_clr = '0;
    endtask

    initial begin
        logic [NP-1:0] exp_snoop;

        vecs[0] = '{24'h000000, 24'h000008, 24'h000008, 24'h000008, 24'h000008};
        vecs[1] = '{24'h000000, 24'h000000, 24'h000008, 24'h000008, 24'h000000};
        vecs[2] = '{24'h000020, 24'h000000, 24'h000000, 24'h000000, 24'h000020};
        vecs[3] = '{24'h000020, 24'h000000, 24'h000020, 24'h000000, 24'h000000};
        vecs[4] = '{24'hFFFFFF, 24'hFFFFFF, 24'hA5A5A5, 24'h000000, 24'h5A5A5A};
        vecs[5] = '{24'h00FF00, 24'hF0F0F0, 24'h0F0FFF, 24'h0F00FF, 24'hF0F0F0};
        vecs[6] = '{24'h000000, 24'hFFFFFF, 24'h123456, 24'h123456, 24'hFFFFFF};
        vecs[7] = '{24'h000008, 24'hFFFFFF, 24'h123456, 24'h123456, 24'hFFFFFF};

        rst = 1'b1;
        core_out = '0; core_oe = '0; od_en = '0; pad_in = IDLE;
        filt_thresh = '0; rise_ie = '0; fall_ie = '0; evt_clr = '0;
        step(1);
        check("rst_pad_oe", pad_oe, 24'h0);
        check("rst_core_in", core_in, IDLE);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        step(4);
        check("idle_sts", rise_sts | fall_sts, 24'h0);

        // Output path table, pad_in held at IDLE
        for (int i = 0; i < 8; i++) begin
            od_en = vecs[i].od; core_oe = vecs[i].oe; core_out = vecs[i].out;
            step(1);
            exp_snoop = (vecs[i].exp_oe & vecs[i].exp_out) | (~vecs[i].exp_oe & IDLE);
            check($sformatf("v%0d_pad_out", i), pad_out, vecs[i].exp_out);
            check($sformatf("v%0d_pad_oe", i), pad_oe, vecs[i].exp_oe);
            check($sformatf("v%0d_snoop", i), pad_snoop, exp_snoop);
            check($sformatf("v%0d_core_in", i), core_in, IDLE);
        end
        core_oe = '0; od_en = '0; core_out = '0;

        // Latency, rise event and irq on pin 0
        rise_ie = 24'h000001;
        pad_in = IDLE | 24'h1;
        step(2);
        check("lat_c2_core_in", core_in, IDLE);
        step(1);
        check("lat_c3_core_in", core_in, IDLE | 24'h1);
        check("lat_c3_rise", rise_sts, 24'h0);
        step(1);
        check("lat_c4_rise", rise_sts, 24'h1);
        check("lat_c4_irq", irq, 0);
        step(1);
        check("lat_c5_irq", irq, 1);
        evt_clr = 24'h1;
        step(1);
        evt_clr = '0;
        check("clr_rise", rise_sts, 24'h0);
        check("clr_irq_lag", irq, 1);
        step(1);
        check("clr_irq", irq, 0);
        pad_in = IDLE;
        step(4);
        check("fall_sts0", fall_sts, 24'h1);
        step(1);
        check("fall_no_ie_irq", irq, 0);
        clear_all();
        check("fall_clr", fall_sts, 24'h0);
        rise_ie = '0;

        // Set and clear in the same cycle on pin 2
        pad_in = IDLE | 24'h4;
        step(3);
        evt_clr = 24'h4;
        step(1);
        evt_clr = '0;
        check("coll_rise", rise_sts, 24'h4);
        check("coll_fall_unset", fall_sts, 24'h0);
        step(1);
        check("coll_hold", rise_sts, 24'h4);
        clear_all();
        check("coll_clr", rise_sts, 24'h0);
        pad_in = IDLE;
        step(5);
        clear_all();
        check("coll_fall_clr", fall_sts, 24'h0);

`ifdef PAD_IO_GLITCH_FILTER_EN
        // Glitch filter on pin 7, threshold 4
        filt_thresh = 4'd4;
        pad_in = IDLE | 24'h80;
        step(4);
        pad_in = IDLE;
        step(2);
        check("glitch_mid", core_in, IDLE);
        step(8);
        check("glitch_core_in", core_in, IDLE);
        check("glitch_sts", rise_sts | fall_sts, 24'h0);
        pad_in = IDLE | 24'h80;
        step(5);
        pad_in = IDLE;
        step(1);
        check("pulse_c6", core_in, IDLE);
        step(1);
        check("pulse_c7", core_in, IDLE | 24'h80);
        step(1);
        check("pulse_rise", rise_sts, 24'h80);
        step(3);
        check("pulse_c11", core_in, IDLE | 24'h80);
        step(1);
        check("pulse_c12", core_in, IDLE);
        step(1);
        check("pulse_fall", fall_sts, 24'h80);
        filt_thresh = '0;
        clear_all();
`endif

        // Reset mid-transfer with every output enabled
        clear_all();
        core_oe = '1; core_out = '1; od_en = '0;
        pad_in = IDLE | 24'h1;
        step(4);
        check("pre_rst_oe", pad_oe, 24'hFFFFFF);
        check("pre_rst_rise", rise_sts, 24'h1);
        rst = 1'b1;
        pad_in = IDLE;
        step(1);
        check("mid_rst_oe", pad_oe, 24'h0);
        check("mid_rst_out", pad_out, 24'h0);
        check("mid_rst_sts", rise_sts | fall_sts, 24'h0);
        check("mid_rst_core_in", core_in, IDLE);
        check("mid_rst_irq", irq, 0);
        rst = 1'b0;
        step(1);
        check("post_rst_oe", pad_oe, 24'hFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
